csr_serial_ctrl: RTL and testbench

Pipeline control unit for the RV32I core that generates the per-stage bubble and flush signals consumed by every IF/ID/EX/MEM/WB segment register, including the CSR EX/MEM data register. It resolves data-cache stalls, branch/jump redirects and load-use hazards. It also serializes CSR instructions: older instructions drain, the CSR instruction issues alone, and younger fetch is held until the CSR write has retired.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/csr_serial_fsm.sv | 75 +++++++
 rtl/csr_serial_ctrl.sv | 95 +++++++++
 tb/tb_csr_serial_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: CSR serialization states, default latencies
// and the per-stage control vector used by the bubble/flush mux.
package pipe_ctrl_pkg;

  localparam int unsigned WB_LAT_DEFAULT = 3;
  localparam int unsigned CNT_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } csr_state_e;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_vec_t;

endpackage

// File: rtl/csr_serial_fsm.sv
// CSR serialization sequencer: drains older work, issues the CSR alone and
// waits for its write-back; also counts issued CSRs.
module csr_serial_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = WB_LAT_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  localparam int unsigned WCNT_W = $clog2(WB_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_en_ID,
  input  logic              any_valid,
  input  logic              br_taken_EX,
  input  logic              dcache_miss,
  output csr_state_e        state,
  output logic [WCNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0]  serial_cnt
);

  csr_state_e        state_n;
  logic [WCNT_W-1:0] wait_cnt_n;
  logic [CNT_W-1:0]  serial_cnt_n;

  // State, wait counter and issue counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      serial_cnt <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      serial_cnt <= serial_cnt_n;
    end
  end

  // Next-state logic; a cache miss freezes everything
  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    serial_cnt_n = serial_cnt;
    if (!dcache_miss) begin
      unique case (state)
        IDLE: begin
          if (csr_en_ID && !br_taken_EX) begin
            state_n = any_valid ? DRAIN : ISSUE;
          end
        end
        DRAIN: begin
          // A younger-than-branch CSR in ID gets squashed by the redirect
          if (br_taken_EX) begin
            state_n = IDLE;
          end else if (!any_valid) begin
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          serial_cnt_n = serial_cnt + CNT_W'(1);
          wait_cnt_n   = WCNT_W'(WB_LAT - 1);
          state_n      = WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state_n = IDLE;
          end else begin
            wait_cnt_n = wait_cnt - WCNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/csr_serial_ctrl.sv
// RV32I pipeline hazard control: per-stage bubble/flush generation with
// data-cache stall, redirect, load-use and CSR serialization handling.
module csr_serial_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = WB_LAT_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_en_ID,
  input  logic             valid_E,
  input  logic             valid_M,
  input  logic             valid_W,
  input  logic             br_taken_EX,
  input  logic             jal_ID,
  input  logic             load_use_ID,
  input  logic             dcache_miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             csr_busy,
  output logic [CNT_W-1:0] csr_serial_cnt
);

  localparam int unsigned WCNT_W = $clog2(WB_LAT + 1);

  csr_state_e        state;
  logic [WCNT_W-1:0] wait_cnt;
  stage_vec_t        bub;
  stage_vec_t        fl;

  csr_serial_fsm #(
    .WB_LAT (WB_LAT),
    .CNT_W  (CNT_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .csr_en_ID   (csr_en_ID),
    .any_valid   (valid_E | valid_M | valid_W),
    .br_taken_EX (br_taken_EX),
    .dcache_miss (dcache_miss),
    .state       (state),
    .wait_cnt    (wait_cnt),
    .serial_cnt  (csr_serial_cnt)
  );

  assign csr_busy = (state != IDLE);

  // Priority mux; each branch drives a disjoint bubble/flush set per stage
  always_comb begin
    bub = '0;
    fl  = '0;
    if (rst) begin
      fl = '1;
    end else if (dcache_miss) begin
      bub = '1;
    end else if (br_taken_EX) begin
      fl.d = 1'b1;
      fl.e = 1'b1;
    end else if (state == DRAIN) begin
      bub.f = 1'b1;
      bub.d = 1'b1;
      fl.e  = 1'b1;
    end else if (state == ISSUE || state == WAIT) begin
      bub.f = 1'b1;
      fl.d  = 1'b1;
    end else if (load_use_ID) begin
      bub.f = 1'b1;
      bub.d = 1'b1;
      fl.e  = 1'b1;
    end else if (jal_ID) begin
      fl.d = 1'b1;
    end
  end

  assign bubbleF = bub.f;
  assign bubbleD = bub.d;
  assign bubbleE = bub.e;
  assign bubbleM = bub.m;
  assign bubbleW = bub.w;
  assign flushF  = fl.f;
  assign flushD  = fl.d;
  assign flushE  = fl.e;
  assign flushM  = fl.m;
  assign flushW  = fl.w;

endmodule

// File: tb/tb_csr_serial_ctrl.sv
// Bench for csr_serial_ctrl: directed scenarios then random traffic, checked
// cycle by cycle against a sequence-level model of CSR serialization.
module tb_csr_serial_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned WB_LAT = WB_LAT_DEFAULT;
  localparam int unsigned CNT_W  = 32;

  logic clk, rst;
  logic csr_en_ID, valid_E, valid_M, valid_W, br_taken_EX, jal_ID, load_use_ID, dcache_miss;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic csr_busy;
  logic [CNT_W-1:0] csr_serial_cnt;

  csr_serial_ctrl #(.WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .csr_en_ID(csr_en_ID),
    .valid_E(valid_E), .valid_M(valid_M), .valid_W(valid_W),
    .br_taken_EX(br_taken_EX), .jal_ID(jal_ID), .load_use_ID(load_use_ID),
    .dcache_miss(dcache_miss),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .csr_busy(csr_busy), .csr_serial_cnt(csr_serial_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bf_seen = 0;
  int busy_seen = 0;

  // Model: draining flag, remaining fetch-hold cycles (ISSUE + WAIT), CSR count
  bit              m_drain;
  int              m_hold;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_drain = 1'b0;
    m_hold  = 0;
    m_cnt   = '0;
  endtask

  function automatic logic any_valid();
    return valid_E | valid_M | valid_W;
  endfunction

  // {bubbleF..W, flushF..W}
  function automatic logic [9:0] exp_ctrl();
    if (rst)                    return 10'b00000_11111;
    if (dcache_miss)            return 10'b11111_00000;
    if (br_taken_EX)            return 10'b00000_01100;
    if (m_drain)                return 10'b11000_00100;
    if (m_hold > 0)             return 10'b10000_01000;
    if (load_use_ID)            return 10'b11000_00100;
    if (jal_ID)                 return 10'b00000_01000;
    return 10'b0;
  endfunction

  function automatic int exp_wait_cnt();
    return (m_hold > 0 && m_hold <= int'(WB_LAT)) ? m_hold - 1 : 0;
  endfunction

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (!dcache_miss) begin
      if (m_hold > 0) begin
        if (m_hold == int'(WB_LAT) + 1) m_cnt = m_cnt + 1'b1;
        m_hold = m_hold - 1;
      end else if (m_drain) begin
        if (br_taken_EX) begin
          m_drain = 1'b0;
        end else if (!any_valid()) begin
          m_drain = 1'b0;
          m_hold  = int'(WB_LAT) + 1;
        end
      end else if (csr_en_ID && !br_taken_EX) begin
        if (any_valid()) m_drain = 1'b1;
        else             m_hold  = int'(WB_LAT) + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":ctrl"},
        {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushF, flushD, flushE, flushM, flushW},
        64'(exp_ctrl()));
    chk({tag, ":busy"}, 64'(csr_busy), 64'(m_drain || m_hold > 0));
    chk({tag, ":cnt"}, 64'(csr_serial_cnt), 64'(m_cnt));
    chk({tag, ":wait_cnt"}, 64'(dut.u_fsm.wait_cnt), 64'(exp_wait_cnt()));
  endtask

  // Settle, check against model, clock, advance model
  task automatic tick(input string tag);
    #1;
    if (rst) model_reset();
    check_all(tag);
    if (bubbleF) bf_seen++;
    if (csr_busy) busy_seen++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    csr_en_ID = 0; valid_E = 0; valid_M = 0; valid_W = 0;
    br_taken_EX = 0; jal_ID = 0; load_use_ID = 0; dcache_miss = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    tick("reset");
    tick("reset2");
    rst = 1'b0;
    tick("idle");

    // CSR with empty pipeline: ISSUE + WB_LAT WAIT cycles
    bf_seen = 0;
    csr_en_ID = 1;
    tick("empty_idle");
    csr_en_ID = 0;
    for (int i = 0; i < 6; i++) tick("empty_seq");
    chk("empty_bubbleF_len", 64'(bf_seen), 64'(WB_LAT + 1));
    chk("empty_cnt", 64'(csr_serial_cnt), 64'd1);

    // CSR behind two in-flight instructions
    csr_en_ID = 1; valid_E = 1; valid_M = 1;
    tick("drain_enter");
    tick("drain1");
    chk("drain_flushE", 64'(flushE), 64'd1);
    tick("drain2");
    valid_E = 0; valid_M = 0;
    tick("drain_exit");
    csr_en_ID = 0;
    for (int i = 0; i < 5; i++) tick("drain_issue_wait");

    // Branch in EX while draining squashes the CSR
    csr_en_ID = 1; valid_E = 1;
    tick("br_enter");
    br_taken_EX = 1;
    tick("br_drain");
    br_taken_EX = 0; csr_en_ID = 0; valid_E = 0;
    tick("br_after");
    chk("br_busy", 64'(csr_busy), 64'd0);
    chk("br_cnt", 64'(csr_serial_cnt), 64'd2);

    // Miss for 5 cycles in the middle of WAIT
    busy_seen = 0;
    csr_en_ID = 1;
    tick("miss_idle");
    csr_en_ID = 0;
    tick("miss_issue");
    tick("miss_wait1");
    dcache_miss = 1;
    for (int i = 0; i < 5; i++) tick("miss_frozen");
    dcache_miss = 0;
    for (int i = 0; i < 6; i++) tick("miss_resume");
    chk("miss_busy_len", 64'(busy_seen), 64'(WB_LAT + 1 + 5));

    // Load-use and jal together in IDLE
    load_use_ID = 1; jal_ID = 1;
    tick("lu_jal");
    chk("lu_jal_flushD", 64'(flushD), 64'd0);
    load_use_ID = 0; jal_ID = 0;

    // Back-to-back CSRs: second accepted the cycle WAIT ends
    csr_en_ID = 1;
    for (int i = 0; i < 2 * (WB_LAT + 1) + 1; i++) tick("b2b");
    csr_en_ID = 0;
    for (int i = 0; i < 5; i++) tick("b2b_tail");

    // Reset pulsed mid-WAIT
    csr_en_ID = 1;
    tick("rst_idle");
    csr_en_ID = 0;
    tick("rst_issue");
    tick("rst_wait");
    rst = 1;
    tick("rst_async");
    chk("rst_flushW", 64'(flushW), 64'd1);
    rst = 0;
    tick("rst_release");
    chk("rst_cnt", 64'(csr_serial_cnt), 64'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      csr_en_ID   = ($urandom_range(0, 99) < 25);
      valid_E     = ($urandom_range(0, 99) < 35);
      valid_M     = ($urandom_range(0, 99) < 35);
      valid_W     = ($urandom_range(0, 99) < 35);
      br_taken_EX = ($urandom_range(0, 99) < 10);
      jal_ID      = ($urandom_range(0, 99) < 12);
      load_use_ID = ($urandom_range(0, 99) < 12);
      dcache_miss = ($urandom_range(0, 99) < 12);
      rst         = ($urandom_range(0, 299) == 0);
      tick("rand");
    end
    rst = 0;
    idle_inputs();
    tick("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
